// File: rtl/regfile_writeback_unit.sv
// Write-back stage: retires one EXU instruction at a time, waits for LSU data on
// loads, sign/zero-extends it and drives a one-cycle register-file write + commit.
// Optional feature macro: WB_LOAD_TIMEOUT_EN (bounds LOAD_WAIT to LOAD_TIMEOUT cycles).
module regfile_writeback_unit #(
    parameter int ISA_WIDTH    = 32,
    parameter int REG_ADDR     = 5,
    parameter int LOAD_TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [REG_ADDR-1:0]  i_rd,
    input  logic                 i_rd_wen,
    input  logic                 i_is_load,
    input  logic [2:0]           i_ld_funct3,
    input  logic [1:0]           i_ld_addr_lo,
    input  logic [ISA_WIDTH-1:0] i_alu_res,
    input  logic [ISA_WIDTH-1:0] i_pc,
    input  logic                 i_ld_valid,
    input  logic [ISA_WIDTH-1:0] i_ld_data,
    input  logic                 i_ld_err,
    output logic                 o_wen,
    output logic [REG_ADDR-1:0]  o_waddr,
    output logic [ISA_WIDTH-1:0] o_wdata,
    output logic                 o_commit,
    output logic [ISA_WIDTH-1:0] o_commit_pc,
    output logic                 o_err,
    output logic                 o_pend_valid,
    output logic [REG_ADDR-1:0]  o_pend_rd,
    output logic                 o_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_WAIT, S_COMMIT} state_e;

    state_e                 state_q, state_d;
    logic [REG_ADDR-1:0]    rd_q, rd_d;
    logic                   rd_wen_q, rd_wen_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic [ISA_WIDTH-1:0]   data_q, data_d;
    logic [ISA_WIDTH-1:0]   pc_q, pc_d;
    logic                   err_q, err_d;
    logic                   ld_timeout;
    logic                   rd_live;

    // A write is only meaningful for an enabled, non-x0 destination
    assign rd_live = rd_wen_q & (rd_q != '0);

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CW = $clog2(LOAD_TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is held at zero outside LOAD_WAIT so it starts fresh on every entry
    always_comb begin
        cnt_d = '0;
        if (state_q == S_LOAD_WAIT) cnt_d = cnt_q + 1'b1;
    end

    // Load-wait cycle counter
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    // Data arriving on the last allowed cycle beats the timeout
    assign ld_timeout = (state_q == S_LOAD_WAIT) & ~i_ld_valid &
                        (cnt_q == CW'(LOAD_TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (LOAD_TIMEOUT > 0);
    assign ld_timeout = 1'b0;
`endif

    // Extend the raw load word according to the latched funct3 / address offset
    logic [ISA_WIDTH-1:0] ld_shift;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [ISA_WIDTH-1:0] ld_ext;
    always_comb begin
        ld_shift = i_ld_data >> {addr_lo_q, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = addr_lo_q[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{(ISA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(ISA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(ISA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(ISA_WIDTH-16){1'b0}}, ld_half};
            default: ld_ext = i_ld_data;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (i_valid) state_d = i_is_load ? S_LOAD_WAIT : S_COMMIT;
            S_LOAD_WAIT: if (i_ld_valid || ld_timeout) state_d = S_COMMIT;
            S_COMMIT:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM outputs: everything is qualified by state so idle outputs read as zero
    always_comb begin
        o_ready      = (state_q == S_IDLE);
        o_commit     = (state_q == S_COMMIT);
        o_wen        = 1'b0;
        o_waddr      = '0;
        o_wdata      = '0;
        o_commit_pc  = '0;
        o_err        = 1'b0;
        o_pend_valid = 1'b0;
        o_pend_rd    = '0;
        o_timeout    = ld_timeout;
        if (state_q == S_COMMIT) begin
            o_wen       = rd_live & ~err_q;
            o_waddr     = rd_q;
            o_wdata     = data_q;
            o_commit_pc = pc_q;
            o_err       = err_q;
        end
        if (state_q != S_IDLE && rd_live) begin
            o_pend_valid = 1'b1;
            o_pend_rd    = rd_q;
        end
    end

    // Instruction latches: captured on accept, load data/err overwritten on arrival
    always_comb begin
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        data_d    = data_q;
        pc_d      = pc_q;
        err_d     = err_q;
        if (state_q == S_IDLE && i_valid) begin
            rd_d      = i_rd;
            rd_wen_d  = i_rd_wen;
            funct3_d  = i_ld_funct3;
            addr_lo_d = i_ld_addr_lo;
            data_d    = i_alu_res;
            pc_d      = i_pc;
            err_d     = 1'b0;
        end else if (state_q == S_LOAD_WAIT) begin
            if (i_ld_valid) begin
                data_d = ld_ext;
                err_d  = i_ld_err;
            end else if (ld_timeout) begin
                err_d = 1'b1;
            end
        end
    end

    // Latch registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            data_q    <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            data_q    <= data_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Scoreboard bench for regfile_writeback_unit: expected commits are queued when
// stimulus is driven and compared by a monitor whenever the DUT commits.
module tb_regfile_writeback_unit;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  i_rd = '0;
    logic        i_rd_wen = 1'b0;
    logic        i_is_load = 1'b0;
    logic [2:0]  i_ld_funct3 = '0;
    logic [1:0]  i_ld_addr_lo = '0;
    logic [31:0] i_alu_res = '0;
    logic [31:0] i_pc = '0;
    logic        i_ld_valid = 1'b0;
    logic [31:0] i_ld_data = '0;
    logic        i_ld_err = 1'b0;
    logic        o_wen;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic        o_commit;
    logic [31:0] o_commit_pc;
    logic        o_err;
    logic        o_pend_valid;
    logic [4:0]  o_pend_rd;
    logic        o_timeout;

    regfile_writeback_unit #(.ISA_WIDTH(32), .REG_ADDR(5), .LOAD_TIMEOUT(4)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_is_load(i_is_load),
        .i_ld_funct3(i_ld_funct3), .i_ld_addr_lo(i_ld_addr_lo),
        .i_alu_res(i_alu_res), .i_pc(i_pc), .i_ld_valid(i_ld_valid),
        .i_ld_data(i_ld_data), .i_ld_err(i_ld_err), .o_wen(o_wen),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_commit(o_commit),
        .o_commit_pc(o_commit_pc), .o_err(o_err), .o_pend_valid(o_pend_valid),
        .o_pend_rd(o_pend_rd), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference load extension, written with indexed part-selects
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] alo,
                                        input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(alo)*8 +: 8];
        h = alo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Commit monitor
    always @(negedge clk) begin
        if (i_rst_n && o_commit) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", o_commit, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wen",   o_wen,       e.wen);
                chk("waddr", o_waddr,     e.waddr);
                chk("wdata", o_wdata,     e.wdata);
                chk("pc",    o_commit_pc, e.pc);
                chk("err",   o_err,       e.err);
            end
        end else if (i_rst_n && o_wen) begin
            chk("wen_without_commit", o_wen, 1'b0);
        end
    end

    task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                         input logic [2:0] f3, input logic [1:0] alo,
                         input logic [31:0] alu, input logic [31:0] pc);
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", o_ready, 1'b1);
        i_valid = 1'b1; i_rd = rd; i_rd_wen = wen; i_is_load = ld;
        i_ld_funct3 = f3; i_ld_addr_lo = alo; i_alu_res = alu; i_pc = pc;
        if (!ld) sb.push_back('{rd, alu, wen && rd != 0, pc, 1'b0});
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                           input logic [1:0] alo, input logic [31:0] pc,
                           input logic [31:0] data, input logic err, input int dly);
        logic live;
        live = wen && rd != 0;
        issue(rd, wen, 1'b1, f3, alo, 32'hDEAD_0000 ^ pc, pc);
        repeat (dly) begin
            @(negedge clk);
            chk("wait_ready", o_ready, 1'b0);
        end
        @(negedge clk);
        chk("pend_valid", o_pend_valid, live);
        chk("pend_rd",    o_pend_rd,    live ? rd : 5'd0);
        i_ld_valid = 1'b1; i_ld_data = data; i_ld_err = err;
        sb.push_back('{rd, ext(f3, alo, data), live && !err, pc, err});
        @(posedge clk); #1;
        i_ld_valid = 1'b0; i_ld_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_ready",  o_ready,      1'b1);
        chk("rst_commit", o_commit,     1'b0);
        chk("rst_wen",    o_wen,        1'b0);
        chk("rst_pend",   o_pend_valid, 1'b0);
        chk("rst_wdata",  o_wdata,      32'd0);
        repeat (2) @(posedge clk);
        #1 i_rst_n = 1'b1;

        // ALU op: written in the cycle after acceptance
        issue(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234, 32'h100);
        @(negedge clk);
        chk("alu_latency_commit", o_commit, 1'b1);
        chk("alu_latency_ready",  o_ready,  1'b0);

        // rd=x0 and rd_wen=0 still commit without a write
        issue(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hAAAA, 32'h104);
        issue(5'd3, 1'b0, 1'b0, 3'd0, 2'd0, 32'hBBBB, 32'h108);

        // Directed loads
        do_load(5'd6, 1'b1, 3'd0, 2'd3, 32'h200, 32'h80FF_FFFF, 1'b0, 0);
        do_load(5'd7, 1'b1, 3'd4, 2'd3, 32'h204, 32'h80FF_FFFF, 1'b0, 1);
        do_load(5'd8, 1'b1, 3'd5, 2'd2, 32'h208, 32'hBEEF_0000, 1'b0, 2);
        do_load(5'd9, 1'b1, 3'd1, 2'd2, 32'h20C, 32'h8001_0000, 1'b0, 0);
        do_load(5'd10, 1'b1, 3'd2, 2'd1, 32'h210, 32'hCAFE_F00D, 1'b0, 0);
        do_load(5'd11, 1'b1, 3'd2, 2'd0, 32'h214, 32'h1234_5678, 1'b1, 0);
        chk("const_lb",  ext(3'd0, 2'd3, 32'h80FF_FFFF), 32'hFFFF_FF80);
        chk("const_lhu", ext(3'd5, 2'd2, 32'hBEEF_0000), 32'h0000_BEEF);

        // Random mix
        for (int i = 0; i < 24; i++) begin
            logic [2:0] f3s [6];
            f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
            if ($urandom_range(1))
                do_load(5'($urandom), 1'($urandom), f3s[$urandom_range(5)], 2'($urandom),
                        32'h1000 + i * 4, $urandom, ($urandom_range(7) == 0), $urandom_range(3));
            else
                issue(5'($urandom), 1'($urandom), 1'b0, 3'd0, 2'd0, $urandom, 32'h1000 + i * 4);
        end

        // Reset during LOAD_WAIT discards the instruction
        issue(5'd12, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h300);
        @(negedge clk);
        chk("pre_rst_pend", o_pend_rd, 5'd12);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", o_ready,      1'b1);
        chk("mid_rst_pend",  o_pend_valid, 1'b0);
        #1 i_rst_n = 1'b1;
        @(negedge clk);
        i_ld_valid = 1'b1; i_ld_data = 32'h5555_5555;
        @(posedge clk); #1;
        i_ld_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_commit", o_commit, 1'b0);
            chk("post_rst_ready",  o_ready,  1'b1);
        end

`ifdef WB_LOAD_TIMEOUT_EN
        begin
            int n = 0;
            issue(5'd13, 1'b1, 1'b1, 3'd2, 2'd0, 32'h55, 32'h400);
            do begin
                @(negedge clk);
                n++;
            end while (!o_timeout && n < 20);
            chk("timeout_cycles", n, 4);
            sb.push_back('{5'd13, 32'h55, 1'b0, 32'h400, 1'b1});
        end
`else
        issue(5'd13, 1'b1, 1'b1, 3'd2, 2'd0, 32'h55, 32'h400);
        repeat (12) begin
            @(negedge clk);
            chk("no_timeout", o_timeout, 1'b0);
        end
        chk("still_waiting", o_ready, 1'b0);
        i_ld_valid = 1'b1; i_ld_data = 32'h0BAD_BEEF;
        sb.push_back('{5'd13, 32'h0BAD_BEEF, 1'b1, 32'h400, 1'b0});
        @(posedge clk); #1;
        i_ld_valid = 1'b0;
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
